uart_core_param: RTL and testbench

UART_CORE_PARAM -- requirements
Module: uart_core_param

---
 rtl/uart_core_param.sv | 269 ++++++++++++++++++++++++++
 tb/tb_uart_core_param.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core_param.sv
// uart_core_param: UART with TX/RX FIFOs, programmable baud divisor and framing.
// Define UART_CORE_LOOPBACK_EN to widen MODE_IN with a bit[3] internal loopback.
module uart_core_param #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              WR_TX,
    input  logic [DATA_W-1:0] TX_DATA,
    input  logic              RD_RX,
    output logic [DATA_W-1:0] RX_DATA,
    input  logic              SET_DIV,
    input  logic [DIV_W-1:0]  DIV,
    input  logic              SET_MODE,
`ifdef UART_CORE_LOOPBACK_EN
    input  logic [3:0]        MODE_IN,
`else
    input  logic [2:0]        MODE_IN,
`endif
    input  logic              CLR_ERR,
    output logic              TX_FULL,
    output logic              RX_EMPTY,
    output logic [2:0]        ERR,
    output logic              INTERRUPT,
    input  logic              RX,
    output logic              TX
);
`ifdef UART_CORE_LOOPBACK_EN
    localparam int MW = 4;
`else
    localparam int MW = 3;
`endif
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

    logic [DIV_W-1:0]  r_div, r_bcnt;
    logic [MW-1:0]     r_mode;
    logic [2:0]        r_err;
    logic              w_tick;

    logic [DATA_W-1:0] r_tmem [FIFO_DEPTH];
    logic [AW:0]       r_twp, r_trp;
    logic              w_tempty, w_tfull, w_tpush, w_tpop, w_tos_end;
    logic [DATA_W-1:0] w_thead;

    logic [DATA_W-1:0] r_rmem [FIFO_DEPTH];
    logic [AW:0]       r_rwp, r_rrp;
    logic              w_rempty, w_rfull, w_rpush, w_rpop, w_ovr;

    state_t            r_ts, r_rs;
    logic [OW-1:0]     r_tos, r_ros;
    logic [BW-1:0]     r_tbit, r_rbit;
    logic [DATA_W-1:0] r_tsh, r_rsh;
    logic              r_tpb, r_tpen, r_tstop2, r_tstop_n, r_tx;
    logic              r_rx1, r_rx2, r_rx3, w_rx_in, w_ros_end;
    logic              r_rpen, r_rodd, r_rpb, r_rdone, r_rperr, r_rferr;

    assign w_tick = (r_bcnt <= DIV_W'(1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_div  <= DIV_W'(1);
            r_bcnt <= DIV_W'(1);
            r_mode <= '0;
            r_err  <= '0;
        end else begin
            if (SET_DIV)  r_div  <= DIV;
            if (SET_MODE) r_mode <= MODE_IN;
            r_bcnt <= w_tick ? r_div : r_bcnt - 1'b1;
            // a coincident error event survives CLR_ERR
            r_err  <= (CLR_ERR ? 3'b000 : r_err) |
                      {w_ovr, r_rdone & r_rferr, r_rdone & r_rperr};
        end
    end

    assign w_tempty  = (r_twp == r_trp);
    assign w_tfull   = (r_twp[AW] != r_trp[AW]) &&
                       (r_twp[AW-1:0] == r_trp[AW-1:0]);
    assign w_thead   = r_tmem[r_trp[AW-1:0]];
    assign w_tos_end = w_tick && (r_tos == OW'(OVERSAMPLE-1));
    assign w_tpop    = !w_tempty &&
                       ((r_ts == S_IDLE && w_tick) ||
                        (r_ts == S_STOP && w_tos_end &&
                         (!r_tstop2 || r_tstop_n)));
    assign w_tpush   = WR_TX && (!w_tfull || w_tpop);

    assign w_rempty  = (r_rwp == r_rrp);
    assign w_rfull   = (r_rwp[AW] != r_rrp[AW]) &&
                       (r_rwp[AW-1:0] == r_rrp[AW-1:0]);
    assign w_rpop    = RD_RX && !w_rempty;
    assign w_rpush   = r_rdone && (!w_rfull || w_rpop);
    assign w_ovr     = r_rdone && w_rfull && !w_rpop;

    always_ff @(posedge CLK) begin
        if (w_tpush) r_tmem[r_twp[AW-1:0]] <= TX_DATA;
        if (w_rpush) r_rmem[r_rwp[AW-1:0]] <= r_rsh;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_twp <= '0;
            r_trp <= '0;
            r_rwp <= '0;
            r_rrp <= '0;
        end else begin
            if (w_tpush) r_twp <= r_twp + 1'b1;
            if (w_tpop)  r_trp <= r_trp + 1'b1;
            if (w_rpush) r_rwp <= r_rwp + 1'b1;
            if (w_rpop)  r_rrp <= r_rrp + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ts      <= S_IDLE;
            r_tos     <= '0;
            r_tbit    <= '0;
            r_tsh     <= '0;
            r_tpb     <= 1'b0;
            r_tpen    <= 1'b0;
            r_tstop2  <= 1'b0;
            r_tstop_n <= 1'b0;
            r_tx      <= 1'b1;
        end else if (w_tpop) begin
            // frame start: mode is frozen here for the whole frame
            r_ts      <= S_START;
            r_tos     <= '0;
            r_tbit    <= '0;
            r_tsh     <= w_thead;
            r_tpen    <= r_mode[0] ^ r_mode[1];
            r_tpb     <= (^w_thead) ^ r_mode[1];
            r_tstop2  <= r_mode[2];
            r_tstop_n <= 1'b0;
            r_tx      <= 1'b0;
        end else if (w_tick && r_ts != S_IDLE) begin
            r_tos <= r_tos + 1'b1;
            if (w_tos_end) begin
                r_tos <= '0;
                unique case (r_ts)
                    S_START: begin
                        r_ts <= S_DATA;
                        r_tx <= r_tsh[0];
                    end
                    S_DATA: begin
                        if (r_tbit == BW'(DATA_W-1)) begin
                            r_ts <= r_tpen ? S_PAR : S_STOP;
                            r_tx <= r_tpen ? r_tpb : 1'b1;
                        end else begin
                            r_tbit <= r_tbit + 1'b1;
                            r_tsh  <= r_tsh >> 1;
                            r_tx   <= r_tsh[1];
                        end
                    end
                    S_PAR: begin
                        r_ts <= S_STOP;
                        r_tx <= 1'b1;
                    end
                    S_STOP: begin
                        if (r_tstop2 && !r_tstop_n) r_tstop_n <= 1'b1;
                        else r_ts <= S_IDLE;
                    end
                    default: r_ts <= S_IDLE;
                endcase
            end
        end
    end

`ifdef UART_CORE_LOOPBACK_EN
    assign w_rx_in = r_mode[3] ? r_tx : RX;
    assign TX      = r_mode[3] ? 1'b1 : r_tx;
`else
    assign w_rx_in = RX;
    assign TX      = r_tx;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rx1 <= 1'b1;
            r_rx2 <= 1'b1;
            r_rx3 <= 1'b1;
        end else begin
            r_rx1 <= w_rx_in;
            r_rx2 <= r_rx1;
            r_rx3 <= r_rx2;
        end
    end

    assign w_ros_end = (r_ros == OW'(OVERSAMPLE-1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rs    <= S_IDLE;
            r_ros   <= '0;
            r_rbit  <= '0;
            r_rsh   <= '0;
            r_rpen  <= 1'b0;
            r_rodd  <= 1'b0;
            r_rpb   <= 1'b0;
            r_rdone <= 1'b0;
            r_rperr <= 1'b0;
            r_rferr <= 1'b0;
        end else begin
            r_rdone <= 1'b0;
            unique case (r_rs)
                S_IDLE: begin
                    if (r_rx3 && !r_rx2) begin
                        r_rs   <= S_START;
                        r_ros  <= '0;
                        r_rbit <= '0;
                        r_rpen <= r_mode[0] ^ r_mode[1];
                        r_rodd <= r_mode[1];
                    end
                end
                default: begin
                    if (w_tick) begin
                        r_ros <= r_ros + 1'b1;
                        unique case (r_rs)
                            S_START: begin
                                if (r_ros == OW'(OVERSAMPLE/2-1)) begin
                                    r_ros <= '0;
                                    r_rs  <= r_rx2 ? S_IDLE : S_DATA;
                                end
                            end
                            S_DATA: begin
                                if (w_ros_end) begin
                                    r_ros  <= '0;
                                    r_rsh  <= {r_rx2, r_rsh[DATA_W-1:1]};
                                    r_rbit <= r_rbit + 1'b1;
                                    if (r_rbit == BW'(DATA_W-1))
                                        r_rs <= r_rpen ? S_PAR : S_STOP;
                                end
                            end
                            S_PAR: begin
                                if (w_ros_end) begin
                                    r_ros <= '0;
                                    r_rpb <= r_rx2;
                                    r_rs  <= S_STOP;
                                end
                            end
                            S_STOP: begin
                                if (w_ros_end) begin
                                    r_rs    <= S_IDLE;
                                    r_rdone <= 1'b1;
                                    r_rperr <= r_rpen &&
                                               (r_rpb != ((^r_rsh) ^ r_rodd));
                                    r_rferr <= !r_rx2;
                                end
                            end
                            default: r_rs <= S_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign TX_FULL   = w_tfull;
    assign RX_EMPTY  = w_rempty;
    assign RX_DATA   = w_rempty ? '0 : r_rmem[r_rrp[AW-1:0]];
    assign ERR       = r_err;
    assign INTERRUPT = !w_rempty || (|r_err);

endmodule

// File: tb/tb_uart_core_param.sv
// tb_uart_core_param: scoreboard bench for uart_core_param.
// Serial frames are checked against bit lists built from the framing rules.
`timescale 1ns/1ps
module tb_uart_core_param;
`ifdef UART_CORE_LOOPBACK_EN
    localparam int MW = 4;
`else
    localparam int MW = 3;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_tx = 1'b0;
    logic [7:0]    tx_data = 8'h00;
    logic          rd_rx = 1'b0;
    logic [7:0]    rx_data;
    logic          set_div = 1'b0;
    logic [15:0]   div = 16'd1;
    logic          set_mode = 1'b0;
    logic [MW-1:0] mode_in = '0;
    logic          clr_err = 1'b0;
    logic          tx_full, rx_empty, intr, tx;
    logic [2:0]    err;
    logic          rx_drv = 1'b1;
    logic          loop_ext = 1'b0;
    logic          rx_line;

    int            n_chk = 0;
    int            n_pass = 0;
    int            cyc = 0;
    logic [7:0]    exp_q[$];
    bit            mon_en = 1'b0;
    bit            lb_watch = 1'b0;
    bit            lb_low = 1'b0;

    assign rx_line = loop_ext ? tx : rx_drv;

    uart_core_param dut (
        .CLK(clk), .RST(rst),
        .WR_TX(wr_tx), .TX_DATA(tx_data),
        .RD_RX(rd_rx), .RX_DATA(rx_data),
        .SET_DIV(set_div), .DIV(div),
        .SET_MODE(set_mode), .MODE_IN(mode_in),
        .CLR_ERR(clr_err),
        .TX_FULL(tx_full), .RX_EMPTY(rx_empty),
        .ERR(err), .INTERRUPT(intr),
        .RX(rx_line), .TX(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // scoreboard monitor: pops the reference queue whenever RX data appears
    always @(negedge clk) begin
        if (rd_rx) rd_rx = 1'b0;
        else if (mon_en && !rx_empty) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL rx_unexpected: got 0x%0h, want nothing", rx_data);
            end else begin
                check("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
            end
            rd_rx = 1'b1;
        end
        if (lb_watch && tx !== 1'b1) lb_low = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input logic [15:0] d, input logic [3:0] m);
        @(negedge clk);
        div = d; mode_in = m[MW-1:0]; set_div = 1'b1; set_mode = 1'b1;
        @(negedge clk);
        set_div = 1'b0; set_mode = 1'b0;
    endtask

    task automatic set_md(input logic [3:0] m);
        @(negedge clk);
        mode_in = m[MW-1:0]; set_mode = 1'b1;
        @(negedge clk);
        set_mode = 1'b0;
    endtask

    task automatic write_tx(input logic [7:0] d);
        @(negedge clk);
        wr_tx = 1'b1; tx_data = d;
        @(negedge clk);
        wr_tx = 1'b0;
    endtask

    task automatic clear_err;
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
    endtask

    task automatic wait_drain(input int lim, input string nm);
        int i = 0;
        while ((exp_q.size() != 0 || !rx_empty) && i < lim) begin
            @(negedge clk);
            i++;
        end
        check(nm, exp_q.size(), 0);
    endtask

    // pm: 0 none, 1 even, 2 odd; bt = CLK cycles per bit
    task automatic tx_frame(input logic [7:0] d, input int pm, input bit s2,
                            input int bt, output int t0);
        int i = 0;
        while (tx !== 1'b0 && i < 20000) begin
            @(negedge clk);
            i++;
        end
        t0 = cyc;
        if (tx !== 1'b0) begin
            check("tx_start_seen", {31'd0, tx}, 0);
            return;
        end
        tick(bt / 2);
        check("tx_start", {31'd0, tx}, 0);
        for (int b = 0; b < 8; b++) begin
            tick(bt);
            check($sformatf("tx_d%0d", b), {31'd0, tx}, {31'd0, d[b]});
        end
        if (pm == 1 || pm == 2) begin
            tick(bt);
            check("tx_par", {31'd0, tx},
                  ($countones(d) % 2) ^ ((pm == 2) ? 1 : 0));
        end
        tick(bt);
        check("tx_stop1", {31'd0, tx}, 1);
        if (s2) begin
            tick(bt);
            check("tx_stop2", {31'd0, tx}, 1);
        end
    endtask

    task automatic rx_send(input logic [7:0] d, input int pm, input bit bad_par,
                           input bit stop_v, input int bt);
        rx_drv = 1'b0;
        tick(bt);
        for (int b = 0; b < 8; b++) begin
            rx_drv = d[b];
            tick(bt);
        end
        if (pm == 1 || pm == 2) begin
            rx_drv = ((($countones(d) % 2) == 1) ^ (pm == 2)) ^ bad_par;
            tick(bt);
        end
        rx_drv = stop_v;
        tick(bt);
        rx_drv = 1'b1;
        tick(bt);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, t1, dv, nb;
        logic [7:0] b;
        logic [3:0] m;
        tick(4);
        rst = 1'b0;
        check("rst_tx", {31'd0, tx}, 1);
        check("rst_tx_full", {31'd0, tx_full}, 0);
        check("rst_rx_empty", {31'd0, rx_empty}, 1);
        check("rst_intr", {31'd0, intr}, 0);
        check("rst_rx_data", {24'd0, rx_data}, 0);
        check("rst_err", {29'd0, err}, 0);

        set_cfg(16'd2, 4'b0000);
        write_tx(8'hA5);
        fork
            begin
                tx_frame(8'hA5, 0, 1'b0, 32, t0);
                tx_frame(8'h3C, 0, 1'b0, 32, t1);
            end
            write_tx(8'h3C);
        join
        check("frame_len", t1 - t0, 320);
        tick(64);

        set_md(4'b0001);
        write_tx(8'h07);
        fork
            tx_frame(8'h07, 1, 1'b0, 32, t0);
            begin
                tick(100);
                set_md(4'b0010);
            end
        join
        tick(32);
        write_tx(8'h07);
        tx_frame(8'h07, 2, 1'b0, 32, t0);
        tick(32);

        set_md(4'b0100);
        write_tx(8'hC3);
        fork
            begin
                tx_frame(8'hC3, 0, 1'b1, 32, t0);
                tx_frame(8'h96, 0, 1'b1, 32, t1);
            end
            write_tx(8'h96);
        join
        check("stop2_len", t1 - t0, 352);
        tick(64);

        loop_ext = 1'b1;
        mon_en = 1'b1;
        for (int r = 0; r < 5; r++) begin
            dv = $urandom_range(1, 2);
            m = 4'($urandom_range(0, 7));
            set_cfg(16'(dv), m);
            nb = $urandom_range(2, 5);
            for (int k = 0; k < nb; k++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                write_tx(b);
            end
            wait_drain(8000, "loop_drain");
            check("loop_err", {29'd0, err}, 0);
            tick(96);
        end

        loop_ext = 1'b0;
        rx_drv = 1'b1;
        set_cfg(16'd1, 4'b0000);
        exp_q.push_back(8'h3C);
        rx_send(8'h3C, 0, 1'b0, 1'b0, 16);
        wait_drain(400, "ferr_drain");
        check("ferr", {29'd0, err}, 3'b010);
        check("ferr_intr", {31'd0, intr}, 1);
        clear_err();
        check("ferr_clr", {29'd0, err}, 0);
        check("ferr_intr_clr", {31'd0, intr}, 0);

        set_cfg(16'd1, 4'b0001);
        exp_q.push_back(8'h55);
        rx_send(8'h55, 1, 1'b1, 1'b1, 16);
        wait_drain(400, "perr_drain");
        check("perr", {29'd0, err}, 3'b001);
        clear_err();
        set_cfg(16'd1, 4'b0010);
        exp_q.push_back(8'hA7);
        rx_send(8'hA7, 2, 1'b0, 1'b1, 16);
        wait_drain(400, "odd_drain");
        check("odd_ok_err", {29'd0, err}, 0);

        set_cfg(16'd1, 4'b0000);
        @(negedge clk);
        rx_drv = 1'b0;
        tick(2);
        rx_drv = 1'b1;
        tick(300);
        check("glitch_empty", {31'd0, rx_empty}, 1);
        check("glitch_err", {29'd0, err}, 0);

        mon_en = 1'b0;
        tick(2);
        for (int k = 0; k < 17; k++) begin
            b = 8'($urandom);
            if (k < 16) exp_q.push_back(b);
            rx_send(b, 0, 1'b0, 1'b1, 16);
        end
        tick(4);
        check("ovr_err", {29'd0, err}, 3'b100);
        check("ovr_intr", {31'd0, intr}, 1);
        check("ovr_not_empty", {31'd0, rx_empty}, 0);
        mon_en = 1'b1;
        wait_drain(400, "ovr_drain");
        clear_err();
        check("ovr_clr", {29'd0, err}, 0);
        check("ovr_intr_clr", {31'd0, intr}, 0);

        mon_en = 1'b0;
        loop_ext = 1'b1;
        set_cfg(16'd1000, 4'b0000);
        tick(4);
        for (int k = 0; k < 17; k++) begin
            if (k == 15) check("tx_notfull15", {31'd0, tx_full}, 0);
            @(negedge clk);
            b = 8'($urandom);
            wr_tx = 1'b1;
            tx_data = b;
            if (k < 16) exp_q.push_back(b);
        end
        @(negedge clk);
        wr_tx = 1'b0;
        check("tx_full", {31'd0, tx_full}, 1);
        set_cfg(16'd1, 4'b0000);
        mon_en = 1'b1;
        wait_drain(6000, "full_drain");
        tick(400);
        check("full_rx_empty", {31'd0, rx_empty}, 1);
        check("full_err", {29'd0, err}, 0);

        set_cfg(16'd4, 4'b0000);
        write_tx(8'hF0);
        t0 = 0;
        while (tx !== 1'b0 && t0 < 2000) begin
            @(negedge clk);
            t0++;
        end
        check("abort_start", {31'd0, tx}, 0);
        tick(20);
        rst = 1'b1;
        @(negedge clk);
        check("abort_tx", {31'd0, tx}, 1);
        rst = 1'b0;
        check("abort_tx_full", {31'd0, tx_full}, 0);
        check("abort_rx_empty", {31'd0, rx_empty}, 1);
        check("abort_err", {29'd0, err}, 0);
        tick(200);

`ifdef UART_CORE_LOOPBACK_EN
        loop_ext = 1'b0;
        rx_drv = 1'b1;
        set_cfg(16'd1, 4'b1001);
        lb_low = 1'b0;
        lb_watch = 1'b1;
        exp_q.push_back(8'h5A);
        write_tx(8'h5A);
        wait_drain(1000, "lb_drain");
        tick(40);
        lb_watch = 1'b0;
        check("lb_err", {29'd0, err}, 0);
        check("lb_tx_high", {31'd0, lb_low}, 0);
        set_cfg(16'd1, 4'b0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
